// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: data width, iteration
// count, FSM state encodings and a two's-complement helper.
package div_seq_pkg;

  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = 5;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Two's-complement negation; the most negative value maps onto itself.
  function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

  // Magnitude of a signed operand, returned as an unsigned bit pattern.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? neg_val(v) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the E stage and the divider.
interface div_seq_if;
  import div_seq_pkg::*;

  logic              start;
  logic              signed_div;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              cancel;
  logic              stall;
  logic              done;
  logic [1:0]        hilo_we;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output start, signed_div, opa, opb, cancel,
    input  stall, done, hilo_we, hi_out, lo_out
  );

  modport slave (
    input  start, signed_div, opa, opb, cancel,
    output stall, done, hilo_we, hi_out, lo_out
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on the packed {rem,quo} accumulator.
module div_step
  import div_seq_pkg::*;
(
  input  logic [2*DATA_W-1:0] acc_in,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] acc_out
);

  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  // Shift in the next dividend bit and keep the difference when it does not borrow.
  always_comb begin
    rem_sh = acc_in[2*DATA_W-1:DATA_W-1];
    diff   = rem_sh - {1'b0, divisor};
    if (!diff[DATA_W]) begin
      acc_out = {diff[DATA_W-1:0], acc_in[DATA_W-2:0], 1'b1};
    end else begin
      acc_out = {acc_in[2*DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU unit: 1 accept cycle, 32 iterations, 1 DONE cycle.
// Build option: DIV_ZERO_FAST_EN sends a zero divisor straight to DONE in cycle 1.
module div_seq
  import div_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   dvsr;
  logic [DATA_W-1:0]   opa_keep;
  logic                sign_a;
  logic                sign_b;
  logic                sgn_reg;
  logic                zero_div;
  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   lo_reg;

  logic [2*DATA_W-1:0] step_out;
  logic                accept;
  logic                last_step;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  div_step u_step (
    .acc_in  (acc),
    .divisor (dvsr),
    .acc_out (step_out)
  );

  // Handshake outputs: stall covers the accept cycle and the iterations only.
  always_comb begin
    accept      = (state == ST_IDLE) && bus.start && !bus.cancel;
    last_step   = (cnt == CNT_W'(DIV_CYCLES - 1));
    bus.stall   = accept || (state == ST_BUSY);
    bus.done    = (state == ST_DONE) && !bus.cancel;
    bus.hilo_we = bus.done ? 2'b11 : 2'b00;
    bus.hi_out  = hi_reg;
    bus.lo_out  = lo_reg;
  end

  // Sign fix-up of the final step; a zero divisor bypasses it entirely.
  always_comb begin
    fix_lo = step_out[DATA_W-1:0];
    fix_hi = step_out[2*DATA_W-1:DATA_W];
    if (sgn_reg && (sign_a ^ sign_b)) fix_lo = neg_val(fix_lo);
    if (sgn_reg && sign_a)            fix_hi = neg_val(fix_hi);
    if (zero_div) begin
      fix_lo = '1;
      fix_hi = opa_keep;
    end
  end

  // FSM, iteration counter, operand latches and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      dvsr     <= '0;
      opa_keep <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      sgn_reg  <= 1'b0;
      zero_div <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else if (bus.cancel) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sgn_reg  <= bus.signed_div;
            sign_a   <= bus.signed_div && bus.opa[DATA_W-1];
            sign_b   <= bus.signed_div && bus.opb[DATA_W-1];
            acc      <= {{DATA_W{1'b0}},
                         bus.signed_div ? abs_val(bus.opa) : bus.opa};
            dvsr     <= bus.signed_div ? abs_val(bus.opb) : bus.opb;
            opa_keep <= bus.opa;
            zero_div <= (bus.opb == '0);
            cnt      <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (bus.opb == '0) begin
              state  <= ST_DONE;
              hi_reg <= bus.opa;
              lo_reg <= '1;
            end else begin
              state <= ST_BUSY;
            end
`else
            state <= ST_BUSY;
`endif
          end
        end
        ST_BUSY: begin
          acc <= step_out;
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            state  <= ST_DONE;
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios plus random operands
// checked against an arithmetic reference model.
module tb_div_seq;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the divider's documented corner cases.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full transaction starting in the current cycle; checks every cycle until two after DONE.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit s, input string tag);
    logic [31:0] q;
    logic [31:0] r;
    int d;
    ref_div(a, b, s, q, r);
    d = (FAST && b == 32'd0) ? 1 : 33;
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.opa        = a;
    bus.opb        = b;
    for (int c = 0; c <= d + 2; c++) begin
      #4;
      chk({31'd0, bus.stall}, {31'd0, (c < d)}, {tag, "_stall"});
      chk({31'd0, bus.done}, {31'd0, (c == d)}, {tag, "_done"});
      chk({30'd0, bus.hilo_we}, (c == d) ? 32'd3 : 32'd0, {tag, "_hilo_we"});
      if (c >= d) begin
        chk(bus.lo_out, q, {tag, "_lo"});
        chk(bus.hi_out, r, {tag, "_hi"});
      end
      next_cycle();
      bus.start      = 1'b0;
      bus.opa        = $urandom;
      bus.opb        = $urandom;
      bus.signed_div = $urandom_range(0, 1);
    end
    last_hi = r;
    last_lo = q;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opa        = 32'd0;
    bus.opb        = 32'd0;
    bus.cancel     = 1'b0;
    repeat (3) next_cycle();
    #4;
    chk({31'd0, bus.stall}, 32'd0, "rst_stall");
    chk({31'd0, bus.done}, 32'd0, "rst_done");
    chk({30'd0, bus.hilo_we}, 32'd0, "rst_hilo_we");
    chk(bus.hi_out, 32'd0, "rst_hi");
    chk(bus.lo_out, 32'd0, "rst_lo");
    next_cycle();
    rst = 1'b1;
    next_cycle();

    do_div(32'd100, 32'd7, 1'b0, "udiv_100_7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_ovf");
    do_div(32'h1234_5678, 32'd0, 1'b0, "udiv_zero");
    do_div(32'h1234_5678, 32'd0, 1'b1, "sdiv_zero");
    do_div(32'h8765_4321, 32'd0, 1'b1, "sdiv_zero_neg");

    // start together with cancel in IDLE must not be taken
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.opa    = 32'd50;
    bus.opb    = 32'd5;
    #4;
    chk({31'd0, bus.stall}, 32'd0, "startcancel_stall0");
    next_cycle();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    #4;
    chk({31'd0, bus.stall}, 32'd0, "startcancel_stall1");
    chk({31'd0, bus.done}, 32'd0, "startcancel_done");
    next_cycle();

    // cancel in cycle 10, restart in cycle 12 -> done in cycle 45
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa        = 32'd1000;
    bus.opb        = 32'd3;
    for (int c = 0; c <= 11; c++) begin
      if (c == 10) bus.cancel = 1'b1;
      #4;
      chk({31'd0, bus.stall}, {31'd0, (c <= 10)}, "cancel_stall");
      chk({31'd0, bus.done}, 32'd0, "cancel_done");
      chk({30'd0, bus.hilo_we}, 32'd0, "cancel_hilo_we");
      chk(bus.lo_out, last_lo, "cancel_lo_hold");
      chk(bus.hi_out, last_hi, "cancel_hi_hold");
      next_cycle();
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
    end
    do_div(32'd1000, 32'd3, 1'b0, "after_cancel");

    // reset in cycle 20 of BUSY, with an ignored start in cycle 5
    bus.start      = 1'b1;
    bus.signed_div = 1'b1;
    bus.opa        = 32'hDEAD_BEEF;
    bus.opb        = 32'd9;
    for (int c = 0; c <= 20; c++) begin
      if (c == 5) bus.start = 1'b1;
      if (c == 20) rst = 1'b0;
      #4;
      chk({31'd0, bus.stall}, 32'd1, "rstbusy_stall");
      chk({31'd0, bus.done}, 32'd0, "rstbusy_done");
      next_cycle();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #4;
    chk({31'd0, bus.stall}, 32'd0, "postrst_stall");
    chk({30'd0, bus.hilo_we}, 32'd0, "postrst_hilo_we");
    chk(bus.hi_out, 32'd0, "postrst_hi");
    chk(bus.lo_out, 32'd0, "postrst_lo");
    for (int c = 0; c < 40; c++) begin
      #0;
      chk({31'd0, bus.done}, 32'd0, "postrst_no_done");
      chk({31'd0, bus.stall}, 32'd0, "postrst_no_stall");
      next_cycle();
      #4;
    end
    next_cycle();

    // random operands, with zero, small and overflow divisors mixed in
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      bit s;
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        3: if (i % 2 == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      do_div(a, b, s, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
